// File: rtl/serial_frame_rx.sv
// Async serial frame receiver: 1 start, 9 payload bits LSB-first, 1 stop.
// Delivers the 9-bit payload (parity in bit 8) to the downstream parity checker.
module serial_frame_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [8:0] frame_out,
    output logic       frame_valid,
    output logic       framing_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [8:0]    sh;
    logic          rxd_m;
    logic          rxd_s;

    // NOTE: synchroniser flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            sh          <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            framing_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high at its centre was only a glitch.
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        sh  <= {rxd_s, sh[8:1]};
                        if (bit_idx == 4'd8) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            frame_out   <= sh;
                            frame_valid <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    // A line held low must return high before a new start is accepted.
                    if (rxd_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx at 16 clocks per bit.
module tb_serial_frame_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [8:0] frame_out;
    logic       frame_valid;
    logic       framing_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         cyc = 0;
    int         v_time[$];
    logic [8:0] v_data[$];
    int         err_cnt = 0;
    logic       prev_valid = 1'b0;
    logic       prev_err = 1'b0;
    logic       overlap_seen = 1'b0;
    logic       wide_seen = 1'b0;

    serial_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) begin
            v_time.push_back(cyc);
            v_data.push_back(frame_out);
        end
        if (framing_err) err_cnt++;
        if (frame_valid && framing_err) overlap_seen = 1'b1;
        if ((frame_valid && prev_valid) || (framing_err && prev_err)) wide_seen = 1'b1;
        prev_valid = frame_valid;
        prev_err   = framing_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rxd = b;
        wait_clks(CPB - 1);
    endtask

    task automatic send_frame(input logic [8:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 9; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    initial begin
        int base;
        int t0;
        logic dropped;

        rst_n = 1'b0;
        rxd   = 1'b1;
        #23;
        check("rst_frame_out", frame_out, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_err", framing_err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(4);

        // Reset in the middle of the data bits.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_frame_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_err", framing_err, 0);
        check("mid_rst_frame_out", frame_out, 0);
        rxd = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_clks(500);
        check("post_rst_no_valid", v_time.size(), 0);
        check("post_rst_no_err", err_cnt, 0);

        // Good frame.
        send_frame(9'h1A5, 1'b1);
        wait_clks(8);
        check("good_valid_count", v_time.size(), 1);
        check("good_frame_out", frame_out, 9'h1A5);
        check("good_parity_odd", ^frame_out, 1);
        check("good_no_err", err_cnt, 0);
        check("good_idle", busy, 0);

        // Glitch on the idle line.
        @(negedge clk);
        rxd = 1'b0;
        wait_clks(5);
        rxd = 1'b1;
        dropped = 1'b0;
        for (int i = 0; i < 10 && !dropped; i++) begin
            @(negedge clk);
            if (!busy) dropped = 1'b1;
        end
        check("glitch_busy_drop", dropped, 1);
        wait_clks(40);
        check("glitch_no_valid", v_time.size(), 1);
        check("glitch_no_err", err_cnt, 0);

        // Framing error followed by a held-low line.
        send_frame(9'h0FF, 1'b0);
        wait_clks(100);
        check("ferr_count", err_cnt, 1);
        check("ferr_frame_out_kept", frame_out, 9'h1A5);
        check("ferr_no_valid", v_time.size(), 1);
        check("ferr_break_busy", busy, 1);
        rxd = 1'b1;
        wait_clks(20);
        check("ferr_recover_idle", busy, 0);
        check("ferr_no_extra_err", err_cnt, 1);

        // Back-to-back frames with no idle gap.
        base = v_time.size();
        send_frame(9'h000, 1'b1);
        send_frame(9'h1FF, 1'b1);
        send_frame(9'h155, 1'b1);
        wait_clks(40);
        check("b2b_count", v_time.size() - base, 3);
        if (v_time.size() >= base + 3) begin
            check("b2b_data0", v_data[base], 9'h000);
            check("b2b_data1", v_data[base + 1], 9'h1FF);
            check("b2b_data2", v_data[base + 2], 9'h155);
            t0 = v_time[base];
            check("b2b_gap01", v_time[base + 1] - t0, 176);
            check("b2b_gap12", v_time[base + 2] - v_time[base + 1], 176);
        end

        // Boundary payloads for bit ordering.
        base = v_time.size();
        send_frame(9'h100, 1'b1);
        wait_clks(8);
        check("bound_100", frame_out, 9'h100);
        send_frame(9'h001, 1'b1);
        wait_clks(8);
        check("bound_001", frame_out, 9'h001);
        check("bound_count", v_time.size() - base, 2);

        check("pulse_overlap", overlap_seen, 0);
        check("pulse_width", wide_seen, 0);
        check("final_err_count", err_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
